// File: rtl/scaler_linebuf4_if.sv
// scaler_linebuf4_if: pixel stream in, 4-tap column stream out
interface scaler_linebuf4_if #(
  parameter int PIXEL_WIDTH = 12,
  parameter int LINE_CNT_WIDTH = 16
);
  logic [PIXEL_WIDTH-1:0] di_i;
  logic de_i, hs_i, vs_i;
  logic [PIXEL_WIDTH-1:0] do0_o, do1_o, do2_o, do3_o;
  logic de_o, hs_o, vs_o;
  logic [LINE_CNT_WIDTH-1:0] line_o;
  logic err_o;
  modport master (
    output di_i, de_i, hs_i, vs_i,
    input do0_o, do1_o, do2_o, do3_o, de_o, hs_o, vs_o, line_o, err_o
  );
  modport slave (
    input di_i, de_i, hs_i, vs_i,
    output do0_o, do1_o, do2_o, do3_o, de_o, hs_o, vs_o, line_o, err_o
  );
endinterface

// File: rtl/scaler_linebuf4.sv
// scaler_linebuf4: rotating 4-line buffer emitting vertically aligned 4-tap pixel columns
module scaler_linebuf4 #(
  parameter int PIXEL_WIDTH = 12,
  parameter int MAX_LINE_WIDTH = 4096,
  parameter int LINE_CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  scaler_linebuf4_if.slave bus
);
  localparam int AW = $clog2(MAX_LINE_WIDTH);
  localparam logic [AW:0] MAXA = MAX_LINE_WIDTH[AW:0];
  localparam logic [AW-1:0] LAST = AW'(MAX_LINE_WIDTH - 1);
  logic locked, acc, ls, ovf;
  logic [1:0] wr_sel, sel_n, s1_sel, vl, vl_n, s1_vl, t1, t2, t3;
  logic [AW:0] wr_addr;
  logic [AW-1:0] wa, ra;
  logic [LINE_CNT_WIDTH-1:0] line_cnt, line_n, s1_line;
  logic s1_de, s1_hs, s1_vs;
  logic [PIXEL_WIDTH-1:0] s1_di;
  logic [3:0][PIXEL_WIDTH-1:0] rd;
  always_comb begin
    ls = bus.de_i && (bus.hs_i || bus.vs_i);
    acc = bus.de_i && (locked || bus.vs_i);
    ovf = !ls && wr_addr >= MAXA;
    wa = ls ? '0 : wr_addr[AW-1:0];
    ra = ovf ? LAST : wa;
    sel_n = !ls ? wr_sel : bus.vs_i ? 2'd0 : wr_sel + 2'd1;
    line_n = !ls ? line_cnt : bus.vs_i ? '0 : (&line_cnt) ? line_cnt : line_cnt + LINE_CNT_WIDTH'(1);
    vl_n = !ls ? vl : bus.vs_i ? 2'd0 : (vl == 2'd3) ? vl : vl + 2'd1;
    t1 = s1_sel - 2'd1;
    t2 = s1_sel - 2'd2;
    t3 = s1_sel - 2'd3;
  end
  // one RAM per rotation slot; read registered in the same cycle as the write
  for (genvar g = 0; g < 4; g++) begin : g_bank
    logic [PIXEL_WIDTH-1:0] mem [MAX_LINE_WIDTH];
    logic [PIXEL_WIDTH-1:0] q;
    always_ff @(posedge clk) begin
      if (acc && !ovf && sel_n == 2'(g)) mem[wa] <= bus.di_i;
      if (acc) q <= mem[ra];
    end
    assign rd[g] = q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked <= 1'b0;
      wr_sel <= '0;
      wr_addr <= '0;
      line_cnt <= '0;
      vl <= '0;
      s1_de <= 1'b0;
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_di <= '0;
      s1_line <= '0;
      s1_vl <= '0;
      s1_sel <= '0;
      bus.de_o <= 1'b0;
      bus.hs_o <= 1'b0;
      bus.vs_o <= 1'b0;
      bus.do0_o <= '0;
      bus.do1_o <= '0;
      bus.do2_o <= '0;
      bus.do3_o <= '0;
      bus.line_o <= '0;
      bus.err_o <= 1'b0;
    end else begin
      if (acc) begin
        locked <= 1'b1;
        wr_sel <= sel_n;
        line_cnt <= line_n;
        vl <= vl_n;
        wr_addr <= ls ? (AW+1)'(1) : ovf ? wr_addr : wr_addr + (AW+1)'(1);
        if (ovf) bus.err_o <= 1'b1;
        s1_di <= bus.di_i;
        s1_hs <= ls;
        s1_vs <= bus.vs_i;
        s1_line <= line_n;
        s1_vl <= vl_n;
        s1_sel <= sel_n;
      end
      s1_de <= acc;
      bus.de_o <= s1_de;
      if (s1_de) begin
        bus.do0_o <= s1_di;
        bus.do1_o <= (s1_vl >= 2'd1) ? rd[t1] : '0;
        bus.do2_o <= (s1_vl >= 2'd2) ? rd[t2] : '0;
        bus.do3_o <= (s1_vl == 2'd3) ? rd[t3] : '0;
        bus.hs_o <= s1_hs;
        bus.vs_o <= s1_vs;
        bus.line_o <= s1_line;
      end
    end
  end
endmodule

// File: tb/tb_scaler_linebuf4.sv
// tb_scaler_linebuf4: random frames checked against a line-history reference model
module tb_scaler_linebuf4;
  localparam int PW = 12, M = 8, LW = 16;
  logic clk = 0, rst = 1;
  scaler_linebuf4_if #(.PIXEL_WIDTH(PW), .LINE_CNT_WIDTH(LW)) bus();
  scaler_linebuf4 #(.PIXEL_WIDTH(PW), .MAX_LINE_WIDTH(M), .LINE_CNT_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic z, de, hs, vs;
    logic [31:0] line;
    logic [3:0][31:0] d;
    logic [3:0] k;
  } exp_t;
  int errors = 0, checks = 0;
  bit m_lock = 0, m_err = 0;
  int m_line = 0, m_vl = 0, m_x = 0;
  int hist [4][M];
  int hlen [4] = '{0, 0, 0, 0};
  exp_t pd1, pd2;
  logic [3:0][PW-1:0] taps;
  assign taps = {bus.do3_o, bus.do2_o, bus.do1_o, bus.do0_o};
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_out();
    if (pd2.z) begin
      check("rst_de", bus.de_o, 0);
      for (int k = 0; k < 4; k++) check($sformatf("rst_do%0d", k), taps[k], 0);
      check("rst_hs", bus.hs_o, 0);
      check("rst_vs", bus.vs_o, 0);
      check("rst_line", bus.line_o, 0);
    end else if (!pd2.de) begin
      check("idle_de", bus.de_o, 0);
    end else begin
      check("de", bus.de_o, 1);
      for (int k = 0; k < 4; k++) if (k == 0 || pd2.k[k]) check($sformatf("do%0d", k), taps[k], pd2.d[k]);
      check("hs", bus.hs_o, pd2.hs);
      check("vs", bus.vs_o, pd2.vs);
      check("line", bus.line_o, pd2.line);
    end
  endtask
  // each line's history slot keeps its pixels; taps reach back k lines in that list
  task automatic step(bit de, bit hs, bit vs, int di);
    exp_t e;
    e = '0;
    @(negedge clk);
    check_out();
    check("err", bus.err_o, m_err);
    bus.de_i = de;
    bus.hs_i = hs;
    bus.vs_i = vs;
    bus.di_i = PW'(di);
    if (de && (m_lock || vs)) begin
      m_lock = 1;
      e.de = 1;
      if (hs || vs) begin
        if (vs) begin
          m_line = 0;
          m_vl = 0;
        end else begin
          m_line = (m_line == 65535) ? m_line : m_line + 1;
          m_vl = (m_vl == 3) ? 3 : m_vl + 1;
        end
        for (int k = 3; k > 0; k--) begin
          hist[k] = hist[k-1];
          hlen[k] = hlen[k-1];
        end
        hlen[0] = 0;
        m_x = 0;
      end
      e.hs = hs || vs;
      e.vs = vs;
      e.line = m_line;
      e.d[0] = di;
      for (int k = 1; k < 4; k++) begin
        int a;
        a = (m_x < M) ? m_x : M - 1;
        if (m_vl < k) begin
          e.k[k] = 1;
          e.d[k] = 0;
        end else if (a < hlen[k]) begin
          e.k[k] = 1;
          e.d[k] = hist[k][a];
        end
      end
      if (m_x < M) begin
        hist[0][m_x] = di;
        hlen[0] = m_x + 1;
      end else m_err = 1;
      m_x++;
    end
    pd2 = pd1;
    pd1 = e;
  endtask
  task automatic idle();
    step(0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 4095)));
  endtask
  task automatic line(bit vs, int w, bit rnd, int l, bit gaps);
    for (int x = 0; x < w; x++) begin
      if (gaps && x > 0 && $urandom_range(0, 3) == 0) idle();
      step(1, x == 0, vs && x == 0, rnd ? int'($urandom_range(0, 4095)) : 16 * l + x);
    end
    if (gaps) repeat ($urandom_range(0, 2)) idle();
  endtask
  task automatic frame(int n, int w, bit rnd, bit gaps);
    for (int l = 0; l < n; l++) line(l == 0, (w == 0) ? int'($urandom_range(1, M)) : w, rnd, l, gaps);
  endtask
  task automatic async_reset();
    exp_t z;
    z = '0;
    z.z = 1;
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("arst_de", bus.de_o, 0);
    for (int k = 0; k < 4; k++) check($sformatf("arst_do%0d", k), taps[k], 0);
    check("arst_hs", bus.hs_o, 0);
    check("arst_vs", bus.vs_o, 0);
    check("arst_line", bus.line_o, 0);
    check("arst_err", bus.err_o, 0);
    bus.de_i = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    m_lock = 0;
    m_err = 0;
    hlen = '{0, 0, 0, 0};
    pd1 = z;
    pd2 = z;
  endtask
  initial begin
    bus.de_i = 0;
    bus.hs_i = 0;
    bus.vs_i = 0;
    bus.di_i = 0;
    pd1 = '0;
    pd1.z = 1;
    pd2 = pd1;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int l = 0; l < 3; l++) line(0, 5, 1, l, 0);
    repeat (3) idle();
    frame(4, 8, 0, 0);
    repeat (2) idle();
    frame(4, 8, 1, 0);
    frame(5, 8, 1, 0);
    for (int f = 0; f < 6; f++) frame(int'($urandom_range(1, 6)), 0, 1, 1);
    line(1, 8, 1, 0, 0);
    line(0, 10, 1, 1, 0);
    line(0, 8, 1, 2, 0);
    line(0, 8, 1, 3, 1);
    frame(3, 6, 1, 1);
    line(1, 8, 1, 0, 0);
    line(0, 3, 1, 1, 0);
    async_reset();
    for (int l = 0; l < 2; l++) line(0, 4, 1, l, 0);
    frame(4, 6, 1, 1);
    repeat (4) idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scaler_linebuf4.md
Name: scaler_linebuf4

Overview:
- Line-buffer stage directly downstream of the horizontal scaler and upstream of the vertical interpolator.
- Stores the last three horizontally-scaled lines in rotating line RAMs.
- For every incoming pixel, emits a vertically aligned 4-tap column: the current pixel plus the same x-position from the three previous lines.
- Also emits the in-frame line index, so the vertical stage can derive its phase and coefficients.

Parameters:
- PIXEL_WIDTH, 12, bits per pixel (matches the horizontal scaler output).
- MAX_LINE_WIDTH, 4096, maximum pixels per line; line-RAM depth.
- LINE_CNT_WIDTH, 16, width of the line index counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- di_i  in  PIXEL_WIDTH  input pixel.
- de_i  in  1  input pixel valid.
- hs_i  in  1  first pixel of line; qualified by de_i.
- vs_i  in  1  first pixel of frame; qualified by de_i.
- do0_o  out  PIXEL_WIDTH  tap 0: current line (n).
- do1_o  out  PIXEL_WIDTH  tap 1: line n-1.
- do2_o  out  PIXEL_WIDTH  tap 2: line n-2.
- do3_o  out  PIXEL_WIDTH  tap 3: line n-3.
- de_o  out  1  taps valid.
- hs_o  out  1  first column of line.
- vs_o  out  1  first column of frame.
- line_o  out  LINE_CNT_WIDTH  in-frame index of line n, starting at 0.
- err_o  out  1  sticky: a line exceeded MAX_LINE_WIDTH.

Behaviour:
- Reset (async assert, sync release) clears:
  - all outputs to 0;
  - wr_sel=0, wr_addr=0, line_cnt=0, valid_lines=0, locked=0, err_o=0.
  - RAM contents are not cleared.
- Sync qualification:
  - hs_i and vs_i are sampled only when de_i=1.
  - de_i&&vs_i is treated as a line start as well, even if hs_i=0.
- Lock:
  - Out of reset, and whenever locked=0, every input is discarded and de_o stays 0.
  - The first de_i&&vs_i sets locked=1 and is processed as a frame start in the same cycle.
- Line start (de_i && (hs_i||vs_i), locked or locking):
  - wr_addr<=1; the pixel is written at address 0.
  - If vs_i: wr_sel<=0, line_cnt<=0, valid_lines<=0.
  - Else: wr_sel<=wr_sel+1 mod 4, line_cnt<=line_cnt+1 (saturating at all-ones), valid_lines<=min(valid_lines+1,3).
- Other de_i cycles:
  - If wr_addr<MAX_LINE_WIDTH: write RAM[wr_sel][wr_addr], then wr_addr++.
  - Else: no write, err_o<=1 (sticky until rst). The tap is still emitted, with taps 1-3 read from address MAX_LINE_WIDTH-1.
- Read path:
  - In the write cycle, the same address is read from the three RAMs (wr_sel-1, wr_sel-2, wr_sel-3) mod 4, using the post-update wr_sel on a line start.
  - Read-before-write conflicts cannot occur (different RAMs).
- Latency is fixed at 2 clk from de_i to de_o.
  - Cycle 1: RAM read registered; di_i delayed to match.
  - Cycle 2: output register.
  - hs_o, vs_o and line_o are delayed identically and stay aligned with de_o.
  - Outputs hold their last values while de_o=0.
- Frame-top boundary:
  - Tap k (k=1..3) outputs 0 when valid_lines<k, using the valid_lines in force for that line.
  - Hence line 0 gives taps {p,0,0,0} and line 1 gives {p,n-1,0,0}.
- Short lines (shorter than the previous line) are legal; no stale-data masking is applied.
- Throughput is one pixel per clk, with no backpressure. Back-to-back lines with no de_i gap are supported.
- Reset mid-frame: the pipeline is flushed (outputs 0), locked=0, and the block waits for the next vs_i.

Test Plan:
- Reset, then a stream without vs_i (hs_i lines only) -> de_o never asserts; after the first vs_i, de_o follows de_i by exactly 2 clk.
- Frame of 4 lines x 8 px, pixel value = 16*line+x -> line 3, x=5 gives do0..3 = 53,37,21,5 and line_o=3; line 0 gives 5,0,0,0; line 1 gives 21,5,0,0.
- Two consecutive frames -> second frame line 0 taps 1-3 are 0 (not previous-frame data); line_o restarts at 0; vs_o is a single pulse aligned with the first de_o.
- Line with continuous de_i and hs_i on the cycle right after the previous line's last pixel -> no dropped pixel; hs_o asserted on exactly one output column.
- MAX_LINE_WIDTH=8, line of 10 px -> err_o rises at the 9th pixel and stays 1 after later normal frames; clears only on rst.
- rst asserted mid-line (asynchronously) -> all outputs 0 immediately; after release, nothing is output until the next de_i&&vs_i.
